bcd_display_converter: RTL and testbench

//   Sequential signed-binary to BCD converter feeding the 7-segment digit decoders.

---
 rtl/bcd_display_converter.sv | 105 ++++++++++
 tb/tb_bcd_display_converter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bcd_display_converter.sv
// Signed binary to BCD converter for the 7-segment stage: a shift-and-add-3 engine
// that retires one bit per clock and publishes sign, low digits and overflow at the end.
module bcd_display_converter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned BCD_DIGITS = 10,
    parameter int unsigned OUT_DIGITS = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WIDTH-1:0]          value_in,
    output logic                      busy,
    output logic                      done,
    output logic [4*OUT_DIGITS-1:0]   bcd_out,
    output logic                      sign_out,
    output logic                      overflow
);

    localparam int unsigned BCD_W = 4 * BCD_DIGITS;
    localparam int unsigned OUT_W = 4 * OUT_DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [BCD_W-1:0]   bcd;
    logic [WIDTH-1:0]   mag;
    logic [CNT_W-1:0]   cnt;
    logic               sign;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   bcd_next;
    logic [WIDTH-1:0]   mag_next;
    logic               last_iter;

    // One double-dabble iteration: correct nibbles >= 5, then shift {bcd,mag} left.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_next  = {adj[BCD_W-2:0], mag[WIDTH-1]};
        mag_next  = {mag[WIDTH-2:0], 1'b0};
        last_iter = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            bcd      <= '0;
            mag      <= '0;
            cnt      <= '0;
            sign     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            sign_out <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        sign  <= value_in[WIDTH-1];
                        // Unsigned reading of the negation makes the most negative value exact.
                        mag   <= value_in[WIDTH-1] ? WIDTH'(~value_in + WIDTH'(1)) : value_in;
                        bcd   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd <= bcd_next;
                    mag <= mag_next;
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        bcd_out  <= bcd_next[OUT_W-1:0];
                        sign_out <= sign;
                        overflow <= |bcd_next[BCD_W-1:OUT_W];
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_converter.sv
// Scoreboard bench for bcd_display_converter: directed values with hand-computed
// BCD results, checked by a monitor whenever done pulses.
module tb_bcd_display_converter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] value_in;
    logic        busy;
    logic        done;
    logic [27:0] bcd_out;
    logic        sign_out;
    logic        overflow;

    typedef struct packed {
        logic [27:0] bcd;
        logic        sign;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [27:0] held_bcd = '0;

    bcd_display_converter dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .value_in (value_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .sign_out (sign_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                exp_t e;
                logic digits_ok;
                e = sb.pop_front();
                check("bcd_out", 32'(bcd_out), 32'(e.bcd));
                check("sign_out", 32'(sign_out), 32'(e.sign));
                check("overflow", 32'(overflow), 32'(e.ovf));
                digits_ok = 1'b1;
                for (int i = 0; i < 7; i++) begin
                    if (bcd_out[4*i +: 4] > 4'd9) digits_ok = 1'b0;
                end
                check("digits_valid", 32'(digits_ok), 32'd1);
            end
        end
    end

    // Start one conversion; optionally poke start (value 5) while busy at edge poke_at.
    task automatic run(input logic [31:0] v, input logic [27:0] eb, input logic es,
                       input logic eo, input int poke_at);
        int   edges;
        int   busy_cnt;
        logic held_ok;
        exp_t e;
        e.bcd = eb; e.sign = es; e.ovf = eo;
        sb.push_back(e);
        start    = 1'b1;
        value_in = v;
        @(posedge clk);
        #1;
        start    = 1'b0;
        value_in = 32'h5A5A_1234;
        busy_cnt = int'(busy);
        edges    = 0;
        held_ok  = 1'b1;
        if (bcd_out !== held_bcd) held_ok = 1'b0;
        forever begin
            if (edges == poke_at) begin
                start    = 1'b1;
                value_in = 32'd5;
            end else begin
                start    = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
            if (done === 1'b1) break;
            busy_cnt += int'(busy);
            if (bcd_out !== held_bcd) held_ok = 1'b0;
            if (edges > 100) begin
                errors++;
                $display("FAIL timeout: got no done after %0d cycles expected 32", edges);
                break;
            end
        end
        start = 1'b0;
        check("latency", 32'(edges), 32'd32);
        check("busy_cycles", 32'(busy_cnt), 32'd32);
        check("hold_midconv", 32'(held_ok), 32'd1);
        held_bcd = eb;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        value_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_sign", 32'(sign_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run(32'd0,          28'h0000000, 1'b0, 1'b0, -1);
        run(32'd1234567,    28'h1234567, 1'b0, 1'b0, -1);
        run(32'hFFFF_FFD6,  28'h0000042, 1'b1, 1'b0, -1);
        run(32'h8000_0000,  28'h7483648, 1'b1, 1'b1, -1);
        run(32'd9999999,    28'h9999999, 1'b0, 1'b0, -1);
        run(32'd10000000,   28'h0000000, 1'b0, 1'b1, -1);
        run(32'hFFFF_FFFF,  28'h0000001, 1'b1, 1'b0, -1);
        run(32'h7FFF_FFFF,  28'h7483647, 1'b0, 1'b1, -1);
        run(32'd12345678,   28'h2345678, 1'b0, 1'b1, 5);
        repeat (40) @(posedge clk);
        #1;
        check("ignored_start_bcd", 32'(bcd_out), 32'h2345678);

        // Reset at cycle 10 of a conversion: aborted, outputs cleared, no done.
        start    = 1'b1;
        value_in = 32'd999;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'd0);
        check("abort_sign", 32'(sign_out), 32'd0);
        check("abort_ovf", 32'(overflow), 32'd0);
        rst = 1'b1;
        held_bcd = '0;
        repeat (40) @(posedge clk);
        #1;
        run(32'd999, 28'h0000999, 1'b0, 1'b0, -1);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
